dwt_updater: RTL and testbench

Update (second lifting) stage of the 5/3 integer DWT datapath. It sits directly downstream of the predictor stage. Per pair it consumes one even sample and the matching detail coefficient, and produces the approximation coefficient s[n] = x[2n] + floor((d[n-1] + d[n] + 2) / 4). The detail coefficient is forwarded unchanged and aligned with s[n], so the next level or the output packer receives matched (s, d) pairs.

---
 rtl/dwt_pkg.sv | 32 +++
 rtl/dwt_updater.sv | 117 +++++++++++
 tb/tb_dwt_updater.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dwt_pkg.sv
// Shared types and constants for the 5/3 lifting DWT datapath.
// Provides the update-stage state enum, rounding constants and a clamp helper.
package dwt_pkg;

   localparam int DATA_W    = 16;
   localparam int UPD_ROUND = 2;
   localparam int UPD_SHIFT = 2;

   typedef enum logic {
      IDLE,
      RUN
   } upd_state_t;

   // Clamp a signed value to the signed range of 'width' bits (width <= 31).
   function automatic logic signed [31:0] sat_signed(
      input logic signed [31:0] value,
      input int unsigned        width
   );
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (width - 1));
      if (value > hi) begin
         sat_signed = hi;
      end else if (value < lo) begin
         sat_signed = lo;
      end else begin
         sat_signed = value;
      end
   endfunction

endpackage

// File: rtl/dwt_updater.sv
// Update (second lifting) stage of the 5/3 integer DWT:
//   s[n] = x[2n] + floor((d[n-1] + d[n] + 2) / 4), d[n] forwarded alongside.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        input pair handshake
//   in_even, in_detail       x[2n] and d[n], signed DATA_W
//   in_first, in_last        frame/row boundary markers
//   out_valid/out_ready      output pair handshake
//   out_approx, out_detail   s[n] and d[n]
//   out_first, out_last      boundary markers aligned with the pair
//   sat_flag, frame_err      one-cycle pulses for clamping / missing in_first
module dwt_updater
   import dwt_pkg::*;
#(
   parameter int DATA_W   = dwt_pkg::DATA_W,
   parameter bit SATURATE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_even,
   input  logic [DATA_W-1:0] in_detail,
   input  logic              in_first,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_approx,
   output logic [DATA_W-1:0] out_detail,
   output logic              out_first,
   output logic              out_last,
   output logic              sat_flag,
   output logic              frame_err
);

   localparam logic signed [DATA_W+1:0] W_ROUND = (DATA_W + 2)'(UPD_ROUND);

   upd_state_t          r_state;
   logic [DATA_W-1:0]   r_d_prev;
   logic                r_valid;
   logic [DATA_W-1:0]   r_approx;
   logic [DATA_W-1:0]   r_detail;
   logic                r_first;
   logic                r_last;
   logic                r_sat;
   logic                r_ferr;

   logic                w_accept;
   logic                w_restart;
   logic [DATA_W-1:0]   w_prev_eff;
   logic signed [DATA_W+1:0] w_sum;
   logic signed [DATA_W+1:0] w_upd;
   logic signed [31:0]  w_res;
   logic signed [31:0]  w_clamped;
   logic                w_sat;
   logic [DATA_W-1:0]   w_approx;

   assign in_ready = !r_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   // Left boundary (IDLE or restart) mirrors d[n] onto d[n-1].
   assign w_restart  = (r_state == IDLE) || in_first;
   assign w_prev_eff = w_restart ? in_detail : r_d_prev;

   assign w_sum = $signed({{2{w_prev_eff[DATA_W-1]}}, w_prev_eff})
                + $signed({{2{in_detail[DATA_W-1]}}, in_detail})
                + W_ROUND;
   assign w_upd = w_sum >>> UPD_SHIFT;

   // Exact sum in 32 bits; the true result always fits in DATA_W+1 bits.
   assign w_res = $signed({{(32-DATA_W){in_even[DATA_W-1]}}, in_even})
                + $signed({{(30-DATA_W){w_upd[DATA_W+1]}}, w_upd});

   assign w_clamped = sat_signed(w_res, DATA_W);
   assign w_sat     = SATURATE && (w_clamped != w_res);
   assign w_approx  = SATURATE ? w_clamped[DATA_W-1:0]
                               : w_res[DATA_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_d_prev <= '0;
         r_valid  <= 1'b0;
         r_approx <= '0;
         r_detail <= '0;
         r_first  <= 1'b0;
         r_last   <= 1'b0;
         r_sat    <= 1'b0;
         r_ferr   <= 1'b0;
      end else begin
         r_sat  <= 1'b0;
         r_ferr <= 1'b0;
         if (w_accept) begin
            r_valid  <= 1'b1;
            r_approx <= w_approx;
            r_detail <= in_detail;
            r_first  <= in_first;
            r_last   <= in_last;
            r_d_prev <= in_detail;
            r_sat    <= w_sat;
            r_ferr   <= (r_state == IDLE) && !in_first;
            r_state  <= in_last ? IDLE : RUN;
         end else if (out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_valid  = r_valid;
   assign out_approx = r_approx;
   assign out_detail = r_detail;
   assign out_first  = r_first;
   assign out_last   = r_last;
   assign sat_flag   = r_sat;
   assign frame_err  = r_ferr;

endmodule

// File: tb/tb_dwt_updater.sv
// Self-checking bench for dwt_updater (DATA_W=16, SATURATE=1).
// Directed scenarios plus a randomized stream against a behavioural model.
module tb_dwt_updater;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_even = '0;
   logic [W-1:0]  in_detail = '0;
   logic          in_first = 1'b0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_approx;
   logic [W-1:0]  out_detail;
   logic          out_first;
   logic          out_last;
   logic          sat_flag;
   logic          frame_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dwt_updater #(.DATA_W(W), .SATURATE(1'b1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_even(in_even), .in_detail(in_detail),
      .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_approx(out_approx), .out_detail(out_detail),
      .out_first(out_first), .out_last(out_last),
      .sat_flag(sat_flag), .frame_err(frame_err)
   );

   // ---------------- behavioural model ----------------
   typedef struct {
      int a;
      int d;
      bit f;
      bit l;
      bit sat;
      bit ferr;
   } exp_t;

   int m_prev;
   bit m_run;

   function automatic int floor_div4(input int x);
      int q;
      q = x / 4;
      if ((x % 4) != 0 && x < 0) q = q - 1;
      return q;
   endfunction

   task automatic model_pair(input int ev, input int d, input bit f,
                             input bit l, output exp_t e);
      int pe;
      int res;
      pe  = (!m_run || f) ? d : m_prev;
      res = ev + floor_div4(pe + d + 2);
      e.sat = 1'b0;
      if (res > 32767) begin res = 32767; e.sat = 1'b1; end
      if (res < -32768) begin res = -32768; e.sat = 1'b1; end
      e.a    = res;
      e.d    = d;
      e.f    = f;
      e.l    = l;
      e.ferr = !m_run && !f;
      m_prev = d;
      m_run  = !l;
   endtask

   task automatic drive(input int ev, input int d, input bit f, input bit l);
      in_valid  = 1'b1;
      in_even   = W'(ev);
      in_detail = W'(d);
      in_first  = f;
      in_last   = l;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_prev = 0;
      m_run  = 1'b0;
   endtask

   // ---------------- directed tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      #2;
      n_checks++;
      if ({out_valid, out_approx, out_detail, out_first, out_last,
           sat_flag, frame_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b a=%0d d=%0d f=%b l=%b s=%b e=%b, need all 0",
                  out_valid, out_approx, out_detail, out_first, out_last,
                  sat_flag, frame_err);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_frame();
      int ev [4] = '{10, 20, 30, 40};
      int dd [4] = '{4, 8, -4, 0};
      int ex [4] = '{12, 23, 31, 39};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(ev[i], dd[i], i == 0, i == 3);
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_in_ready[%0d]: got %b need 1", i, in_ready);
         end
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_approx !== W'(ex[i]) ||
             out_detail !== W'(dd[i]) || out_first !== (i == 0) ||
             out_last !== (i == 3) || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_pair[%0d]: got v=%b a=%0d d=%0d f=%b l=%b e=%b need a=%0d d=%0d",
                     i, out_valid, $signed(out_approx), $signed(out_detail),
                     out_first, out_last, frame_err, ex[i], dd[i]);
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_drain: out_valid got %b need 0", out_valid);
      end
   endtask

   task automatic test_single_pair();
      int ev [3] = '{5, 0, 0};
      int dd [3] = '{-3, 8, 0};
      bit ff [3] = '{1'b1, 1'b1, 1'b0};
      bit ll [3] = '{1'b1, 1'b0, 1'b1};
      int ex [3] = '{4, 4, 2};
      for (int i = 0; i < 3; i++) begin
         drive(ev[i], dd[i], ff[i], ll[i]);
         @(posedge clk); #1;
         n_checks++;
         if (out_approx !== W'(ex[i]) || frame_err !== 1'b0 ||
             out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pair[%0d]: got a=%0d e=%b v=%b need a=%0d e=0 v=1",
                     i, $signed(out_approx), frame_err, out_valid, ex[i]);
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_saturation();
      int ev [4] = '{32767, 32767, -32768, -32768};
      int dd [4] = '{400, 400, -400, -400};
      int ex [4] = '{32767, 32767, -32768, -32768};
      for (int i = 0; i < 4; i++) begin
         drive(ev[i], dd[i], (i % 2) == 0, (i % 2) == 1);
         @(posedge clk); #1;
         n_checks++;
         if (out_approx !== W'(ex[i]) || sat_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate[%0d]: got a=%0d sat=%b need a=%0d sat=1",
                     i, $signed(out_approx), sat_flag, ex[i]);
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (sat_flag !== 1'b0) begin
         n_fail++;
         $display("FAIL saturate_pulse: sat_flag got %b need 0", sat_flag);
      end
   endtask

   task automatic test_backpressure();
      int ev [4] = '{10, 20, 30, 40};
      int dd [4] = '{4, 8, -4, 0};
      int ex [4] = '{12, 23, 31, 39};
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(ev[i], dd[i], i == 0, 1'b0);
         @(posedge clk); #1;
         n_checks++;
         if (out_approx !== W'(ex[i])) begin
            n_fail++;
            $display("FAIL bp_pre[%0d]: got a=%0d need %0d",
                     i, $signed(out_approx), ex[i]);
         end
      end
      drive(ev[2], dd[2], 1'b0, 1'b0);
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
             out_approx !== W'(ex[1]) || out_detail !== W'(dd[1])) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got rdy=%b v=%b a=%0d d=%0d need rdy=0 v=1 a=%0d d=%0d",
                     c, in_ready, out_valid, $signed(out_approx),
                     $signed(out_detail), ex[1], dd[1]);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 2; i < 4; i++) begin
         drive(ev[i], dd[i], 1'b0, i == 3);
         @(posedge clk); #1;
         n_checks++;
         if (out_approx !== W'(ex[i]) || out_detail !== W'(dd[i]) ||
             out_last !== (i == 3)) begin
            n_fail++;
            $display("FAIL bp_post[%0d]: got a=%0d d=%0d l=%b need a=%0d d=%0d",
                     i, $signed(out_approx), $signed(out_detail), out_last,
                     ex[i], dd[i]);
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_frame_err();
      do_reset();
      drive(10, 4, 1'b0, 1'b1);
      @(posedge clk); #1;
      n_checks++;
      if (frame_err !== 1'b1 || out_approx !== W'(12)) begin
         n_fail++;
         $display("FAIL frame_err: got e=%b a=%0d need e=1 a=12",
                  frame_err, $signed(out_approx));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_err_pulse: got %b need 0", frame_err);
      end
   endtask

   task automatic test_reset_mid_frame();
      int ev [3] = '{10, 20, 30};
      int dd [3] = '{4, 8, -4};
      for (int i = 0; i < 3; i++) begin
         drive(ev[i], dd[i], i == 0, 1'b0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({out_valid, out_approx, out_detail, out_first, out_last} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: got v=%b a=%0d d=%0d need all 0",
                  out_valid, $signed(out_approx), $signed(out_detail));
      end
      @(posedge clk); #1;
      rst = 1'b0;
      drive(100, 6, 1'b1, 1'b0);
      @(posedge clk); #1;
      n_checks++;
      if (out_approx !== W'(103) || frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_p0: got a=%0d e=%b need a=103 e=0",
                  $signed(out_approx), frame_err);
      end
      drive(100, 10, 1'b0, 1'b1);
      @(posedge clk); #1;
      n_checks++;
      if (out_approx !== W'(104)) begin
         n_fail++;
         $display("FAIL reset_mid_p1: got a=%0d need 104", $signed(out_approx));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   // ---------------- randomized stream ----------------
   task automatic test_random();
      exp_t q[$];
      exp_t e;
      exp_t cur;
      bit   acc_prev = 1'b0;
      bit   sat_prev = 1'b0;
      bit   ferr_prev = 1'b0;
      int   ev;
      int   dd;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         bit drain;
         drain = cyc >= 560;
         if (!drain && ($urandom_range(0, 9) < 7)) begin
            if ($urandom_range(0, 1) == 1) begin
               ev = int'($urandom_range(0, 65535)) - 32768;
               dd = int'($urandom_range(0, 65535)) - 32768;
            end else begin
               ev = int'($urandom_range(0, 200)) - 100;
               dd = int'($urandom_range(0, 200)) - 100;
            end
            drive(ev, dd, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
         end else begin
            in_valid = 1'b0;
         end
         out_ready = drain || ($urandom_range(0, 3) != 0);
         @(negedge clk);
         n_checks++;
         if (sat_flag !== (acc_prev && sat_prev) ||
             frame_err !== (acc_prev && ferr_prev)) begin
            n_fail++;
            $display("FAIL rand_flags@%0d: got sat=%b err=%b need sat=%b err=%b",
                     cyc, sat_flag, frame_err, acc_prev && sat_prev,
                     acc_prev && ferr_prev);
         end
         n_checks++;
         if (out_valid !== (q.size() != 0)) begin
            n_fail++;
            $display("FAIL rand_valid@%0d: got %b need %b",
                     cyc, out_valid, q.size() != 0);
         end
         if (out_valid && out_ready && q.size() != 0) begin
            cur = q.pop_front();
            n_checks++;
            if (out_approx !== W'(cur.a) || out_detail !== W'(cur.d) ||
                out_first !== cur.f || out_last !== cur.l) begin
               n_fail++;
               $display("FAIL rand_pair@%0d: got a=%0d d=%0d f=%b l=%b need a=%0d d=%0d f=%b l=%b",
                        cyc, $signed(out_approx), $signed(out_detail),
                        out_first, out_last, cur.a, cur.d, cur.f, cur.l);
            end
         end
         acc_prev = in_valid && in_ready;
         if (acc_prev) begin
            model_pair($signed(in_even), $signed(in_detail),
                       in_first, in_last, e);
            q.push_back(e);
            sat_prev  = e.sat;
            ferr_prev = e.ferr;
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL rand_drain: %0d pairs left, need 0", q.size());
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      m_prev = 0;
      m_run  = 1'b0;
      #1;
      test_reset();
      test_frame();
      test_single_pair();
      test_saturation();
      test_backpressure();
      test_frame_err();
      test_reset_mid_frame();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
